piso_serializer: RTL

- Parallel-in/serial-out transmit stage, one word at a time, with a valid/ready load handshake.
- Sits directly upstream of the team's 4-bit SIPO shift register and drives its serial input.
- Emits a frame strobe and last-bit marker so downstream logic knows when the SIPO holds a complete word.
- Default configuration (WIDTH=4, MSB first) reconstructs the word in the SIPO as-is after WIDTH clocks.

---
 rtl/piso_serializer_pkg.sv | 17 +
 rtl/piso_serializer.sv | 115 +++++++++++
 2 files changed

// File: rtl/piso_serializer_pkg.sv
// Shared types and constants for the parallel-in/serial-out transmit stage.
package piso_serializer_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Line level while no frame is being transmitted.
    localparam logic IDLE_LEVEL_DEFAULT = 1'b0;

    // Bit-counter width for a given word width; never narrower than one bit.
    function automatic int cnt_width(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out transmitter with a valid/ready load handshake.
// A loaded word appears on serial_out one bit per clock, starting the cycle
// after the load. A new word may be accepted while the last bit of the current
// word is on the line, so back-to-back words stream with no gap.
//
// state | meaning
// IDLE  | no frame on the line, serial_out at IDLE_LEVEL, ready for a word
// SHIFT | a data bit is on serial_out; cnt_q is its index within the word
module piso_serializer
    import piso_serializer_pkg::*;
#(
    parameter int   WIDTH      = 4,
    parameter bit   MSB_FIRST  = 1'b1,
    parameter logic IDLE_LEVEL = IDLE_LEVEL_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    output logic             load_ready,
    output logic             serial_out,
    output logic             frame_valid,
    output logic             frame_last,
    output logic             busy
);

    localparam int              CNT_W    = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [WIDTH-1:0] hold_q;
    logic             serial_q;
    logic             last_q;
    logic             last_d;
    logic             load_fire;
    logic             at_last;

    // State register and bit counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state, next count and handshake; ready never looks at load_valid.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        load_ready = 1'b0;
        at_last    = (cnt_q == CNT_LAST);
        case (state_q)
            IDLE: begin
                load_ready = !reset;
                if (load_valid && load_ready) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                end
            end
            SHIFT: begin
                load_ready = !reset && at_last;
                if (at_last) begin
                    cnt_d = '0;
                    if (!(load_valid && load_ready)) begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        load_fire = load_valid && load_ready;
        last_d    = (state_d == SHIFT) && (cnt_d == CNT_LAST);
    end

    // Line driver: the first bit leaves straight from load_data, the rest are
    // shifted out of the holding register, which back-fills with zeros.
    always_ff @(posedge clk) begin
        if (reset) begin
            serial_q <= IDLE_LEVEL;
            last_q   <= 1'b0;
            hold_q   <= '0;
        end else begin
            last_q <= last_d;
            if (load_fire) begin
                serial_q <= MSB_FIRST ? load_data[WIDTH-1] : load_data[0];
                hold_q   <= MSB_FIRST ? {load_data[WIDTH-2:0], 1'b0}
                                      : {1'b0, load_data[WIDTH-1:1]};
            end else if (state_d == SHIFT) begin
                serial_q <= MSB_FIRST ? hold_q[WIDTH-1] : hold_q[0];
                hold_q   <= MSB_FIRST ? {hold_q[WIDTH-2:0], 1'b0}
                                      : {1'b0, hold_q[WIDTH-1:1]};
            end else begin
                serial_q <= IDLE_LEVEL;
                hold_q   <= '0;
            end
        end
    end

    assign serial_out  = serial_q;
    assign frame_last  = last_q;
    assign frame_valid = (state_q == SHIFT);
    assign busy        = frame_valid;

endmodule
